// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file x0..x31.
// Two combinational read ports with same-cycle bypass, commit record and instret.
module writeback_regfile #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   SP_RESET = 32'h0004_4000,
  parameter int                CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic             w_reg,
  input  logic [4:0]       dst_addr,
  input  logic [1:0]       wb_sel,
  input  logic [XLEN-1:0]  alu_res,
  input  logic [XLEN-1:0]  load_data,
  input  logic [XLEN-1:0]  link,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             cmt_we,
  output logic [4:0]       cmt_addr,
  output logic [XLEN-1:0]  cmt_data,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0]  regs_q [32];
  logic [XLEN-1:0]  regs_d [32];
  logic             cmt_we_q, cmt_we_d;
  logic [4:0]       cmt_addr_q, cmt_addr_d;
  logic [XLEN-1:0]  cmt_data_q, cmt_data_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic            we;
  logic [XLEN-1:0] wdata;

  always_comb begin
    unique case (1'b1)
      (wb_sel == 2'b01): wdata = load_data;
      (wb_sel == 2'b10): wdata = link;
      default:           wdata = alu_res;
    endcase
    we = wb_valid & w_reg & (dst_addr != 5'd0);
  end

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[dst_addr] = wdata;
    regs_d[0] = '0;
  end

  always_comb begin
    cmt_we_d   = we;
    cmt_addr_d = we ? dst_addr : 5'd0;
    cmt_data_d = we ? wdata : '0;
    instret_d  = instret_q + CNT_W'(wb_valid);
  end

  // Bypass so a consumer in decode sees the value being committed this cycle
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0)
      rs1_data = (we && rs1_addr == dst_addr) ? wdata : regs_q[rs1_addr];
    rs2_data = '0;
    if (rs2_addr != 5'd0)
      rs2_data = (we && rs2_addr == dst_addr) ? wdata : regs_q[rs2_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= (i == 2) ? SP_RESET : '0;
      cmt_we_q   <= 1'b0;
      cmt_addr_q <= 5'd0;
      cmt_data_q <= '0;
      instret_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      cmt_we_q   <= cmt_we_d;
      cmt_addr_q <= cmt_addr_d;
      cmt_data_q <= cmt_data_d;
      instret_q  <= instret_d;
    end
  end

  assign cmt_we   = cmt_we_q;
  assign cmt_addr = cmt_addr_q;
  assign cmt_data = cmt_data_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed cases plus random traffic
// checked every cycle against an array-based register file model.
module tb_writeback_regfile;

  localparam logic [31:0] SP = 32'h0004_4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid, w_reg;
  logic [4:0]  dst_addr, rs1_addr, rs2_addr;
  logic [1:0]  wb_sel;
  logic [31:0] alu_res, load_data, link;
  logic [31:0] rs1_data, rs2_data, cmt_data;
  logic        cmt_we;
  logic [4:0]  cmt_addr;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;
  bit preload = 0;

  logic [31:0] m_regs [32];
  logic        m_cwe;
  logic [4:0]  m_caddr;
  logic [31:0] m_cdata;
  logic [63:0] m_instret;

  writeback_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .w_reg(w_reg),
    .dst_addr(dst_addr), .wb_sel(wb_sel),
    .alu_res(alu_res), .load_data(load_data), .link(link),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .cmt_we(cmt_we), .cmt_addr(cmt_addr), .cmt_data(cmt_data),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wdata();
    if (wb_sel == 2'b01) return load_data;
    if (wb_sel == 2'b10) return link;
    return alu_res;
  endfunction

  function automatic bit m_we();
    return wb_valid && w_reg && dst_addr != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_we() && a == dst_addr) return m_wdata();
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        m_regs[i] <= (i == 2) ? SP : 32'h0;
      m_cwe     <= 1'b0;
      m_caddr   <= 5'd0;
      m_cdata   <= 32'h0;
      m_instret <= 64'h0;
    end else begin
      if (m_we()) m_regs[dst_addr] <= m_wdata();
      m_cwe     <= m_we();
      m_caddr   <= m_we() ? dst_addr : 5'd0;
      m_cdata   <= m_we() ? m_wdata() : 32'h0;
      m_instret <= (preload ? 64'hFFFF_FFFF_FFFF_FFFF : m_instret)
                   + 64'(wb_valid);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("rs1_data", rs1_data, m_read(rs1_addr));
      chk("rs2_data", rs2_data, m_read(rs2_addr));
      chk("cmt_we", cmt_we, m_cwe);
      chk("cmt_addr", cmt_addr, m_caddr);
      chk("cmt_data", cmt_data, m_cdata);
      if (!preload) chk("instret", instret, m_instret);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    wb_valid = 0; w_reg = 0; dst_addr = 0; wb_sel = 0;
    alu_res = 0; load_data = 0; link = 0;
  endtask

  initial begin
    bubble();
    rs1_addr = 0; rs2_addr = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;

    // reset state
    rs1_addr = 2; rs2_addr = 5;
    cmp_en = 1;
    @(negedge clk); #1;
    chk("t1_sp", rs1_data, SP);
    chk("t1_x5", rs2_data, 0);
    chk("t1_instret", instret, 0);
    chk("t1_cmt_we", cmt_we, 0);

    // load writeback with same-cycle bypass
    tick();
    wb_valid = 1; w_reg = 1; dst_addr = 7; wb_sel = 2'b01;
    load_data = 32'hDEAD_BEEF; rs1_addr = 7;
    #1 chk("t2_bypass", rs1_data, 32'hDEAD_BEEF);
    tick();
    bubble();
    #1;
    chk("t2_array", rs1_data, 32'hDEAD_BEEF);
    chk("t2_cmt_we", cmt_we, 1);
    chk("t2_cmt_addr", cmt_addr, 7);
    chk("t2_cmt_data", cmt_data, 32'hDEAD_BEEF);

    // write to x0 retires but is dropped
    tick();
    wb_valid = 1; w_reg = 1; dst_addr = 0; wb_sel = 2'b00;
    alu_res = 32'h1234; rs1_addr = 0;
    #1 chk("t3_x0_read", rs1_data, 0);
    tick();
    // bubble carrying a would-be write to x3
    bubble();
    w_reg = 1; dst_addr = 3; alu_res = 5; rs1_addr = 3;
    #1;
    chk("t3_cmt_we", cmt_we, 0);
    chk("t3_instret", instret, 2);
    tick();
    bubble();
    #1;
    chk("t4_x3", rs1_data, 0);
    chk("t4_instret", instret, 2);
    chk("t4_cmt_we", cmt_we, 0);

    // clean start, then ten retirements with link writes
    rst_n = 0;
    @(negedge clk); #2 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      wb_valid = 1; w_reg = (i % 2 == 0); dst_addr = 5'(10 + i);
      wb_sel = 2'b10; link = 32'h100 + 32'(4 * i);
      rs1_addr = 2; rs2_addr = 5'(10 + i);
    end
    tick();
    bubble();
    rs1_addr = 10; rs2_addr = 12;
    #1;
    chk("t5_instret", instret, 10);
    chk("t5_x10", rs1_data, 32'h100);
    chk("t5_x12", rs2_data, 32'h108);
    rs1_addr = 11;
    #1 chk("t5_x11", rs1_data, 0);
    rs1_addr = 2;
    #1 rst_n = 0;
    #1;
    chk("t5_rst_instret", instret, 0);
    chk("t5_rst_sp", rs1_data, SP);
    chk("t5_rst_x12", rs2_data, 0);
    chk("t5_rst_cmt_we", cmt_we, 0);
    @(negedge clk); #2 rst_n = 1;

    // counter wrap
    tick();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    preload = 1;
    wb_valid = 1; w_reg = 0;
    tick();
    preload = 0;
    bubble();
    #1 chk("t6_wrap", instret, 0);

    // random traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 400; n++) begin
      tick();
      wb_valid  = ($urandom_range(0, 3) != 0);
      w_reg     = ($urandom_range(0, 3) != 0);
      dst_addr  = 5'($urandom_range(0, 31));
      wb_sel    = 2'($urandom_range(0, 3));
      alu_res   = $urandom;
      load_data = $urandom;
      link      = $urandom;
      rs1_addr  = ($urandom_range(0, 2) == 0) ? dst_addr
                                              : 5'($urandom_range(0, 31));
      rs2_addr  = ($urandom_range(0, 2) == 0) ? dst_addr
                                              : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 59) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
    end
    tick();
    bubble();
    @(negedge clk); #1;
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
